// File: rtl/i2c_command_sequencer_pkg.sv
// Shared types and constants for the camera I2C command sequencer.
// Startup table contents, table entry layout and sequencer state encoding.
package i2c_command_sequencer_pkg;

  typedef struct packed {
    logic [7:0]  reg_addr;
    logic [15:0] data;
  } i2c_entry_t;

  localparam int unsigned I2C_INIT_LEN = 7;

  localparam i2c_entry_t I2C_INIT_0 = '{reg_addr: 8'h23, data: 16'h0033};
  localparam i2c_entry_t I2C_INIT_1 = '{reg_addr: 8'h22, data: 16'h0033};
  localparam i2c_entry_t I2C_INIT_2 = '{reg_addr: 8'h04, data: 16'h09FF};
  localparam i2c_entry_t I2C_INIT_3 = '{reg_addr: 8'h03, data: 16'h077F};
  localparam i2c_entry_t I2C_INIT_4 = '{reg_addr: 8'h01, data: 16'h0038};
  localparam i2c_entry_t I2C_INIT_5 = '{reg_addr: 8'h20, data: 16'h0060};
  localparam i2c_entry_t I2C_INIT_6 = '{reg_addr: 8'h1E, data: 16'h4146};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ASSERT = 2'd2,
    ST_GAP    = 2'd3
  } seq_state_e;

  function automatic i2c_entry_t init_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    return I2C_INIT_0;
      3'd1:    return I2C_INIT_1;
      3'd2:    return I2C_INIT_2;
      3'd3:    return I2C_INIT_3;
      3'd4:    return I2C_INIT_4;
      3'd5:    return I2C_INIT_5;
      3'd6:    return I2C_INIT_6;
      default: return I2C_INIT_0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Small synchronous FIFO holding host register/data writes.
// Depth must be a power of two (>= 2); simultaneous push and pop is allowed when full.
module i2c_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wr_data,
  input  logic             pop,
  output logic [Width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(Depth));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/i2c_command_sequencer.sv
// Replays the camera startup register table, then serves queued host writes to the I2C engine.
// Host queue and handshake exist only when I2C_HOST_QUEUE_EN is defined.
module i2c_command_sequencer
  import i2c_command_sequencer_pkg::*;
#(
  parameter int unsigned HoldCycles = 16,
  parameter int unsigned TxnCycles  = 420000,
  parameter int unsigned QueueDepth = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        host_cmd_valid,
  output logic        host_cmd_ready,
  input  logic [7:0]  host_cmd_register,
  input  logic [15:0] host_cmd_data,
  output logic        send_special_i2c_command,
  output logic [7:0]  special_i2c_command_register,
  output logic [15:0] special_i2c_command_data,
  output logic        busy,
  output logic        init_done
);

  localparam int unsigned CntMax = (HoldCycles > TxnCycles) ? HoldCycles : TxnCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_LOAD   = ST_LOAD;
  localparam logic [1:0] S_ASSERT = ST_ASSERT;
  localparam logic [1:0] S_GAP    = ST_GAP;
  localparam logic [2:0] IdxLast  = 3'(I2C_INIT_LEN - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            table_active_q, table_active_d;
  logic            from_table_q, from_table_d;
  logic            init_done_q, init_done_d;
  logic            strobe_q, strobe_d;
  logic            busy_q, busy_d;
  logic [7:0]      reg_q, reg_d;
  logic [15:0]     data_q, data_d;

  logic            q_empty;
  logic            q_pop;
  i2c_entry_t      q_head;
  i2c_entry_t      load_entry;
  logic            start_ok;
  logic            last_entry;

`ifdef I2C_HOST_QUEUE_EN
  logic q_full;
  logic q_push;

  assign host_cmd_ready = !q_full || q_pop;
  assign q_push         = host_cmd_valid && host_cmd_ready;

  i2c_cmd_fifo #(
    .Depth (QueueDepth),
    .Width ($bits(i2c_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (q_push),
    .wr_data ({host_cmd_register, host_cmd_data}),
    .pop     (q_pop),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );
`else
  logic unused_host_c;

  assign host_cmd_ready = 1'b0;
  assign q_empty        = 1'b1;
  assign q_head         = '0;
  assign unused_host_c  = ^{host_cmd_valid, host_cmd_register, host_cmd_data, q_pop};
`endif

  assign start_ok   = start && !init_done_q && !table_active_q;
  assign last_entry = (idx_q == IdxLast);

  // Next-state logic; GAP falls straight through to LOAD when work is pending so writes stay back-to-back.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    table_active_d = table_active_q;
    from_table_d   = from_table_q;
    init_done_d    = init_done_q;
    reg_d          = reg_q;
    data_d         = data_q;
    q_pop          = 1'b0;
    load_entry     = from_table_q ? init_entry(idx_q) : q_head;

    case (state_q)
      S_IDLE: begin
        if (table_active_q) begin
          state_d      = S_LOAD;
          from_table_d = 1'b1;
        end else if (start_ok) begin
          table_active_d = 1'b1;
          idx_d          = 3'd0;
        end else if (!q_empty) begin
          state_d      = S_LOAD;
          from_table_d = 1'b0;
        end
      end
      S_LOAD: begin
        reg_d   = load_entry.reg_addr;
        data_d  = load_entry.data;
        q_pop   = !from_table_q;
        state_d = S_ASSERT;
        cnt_d   = CntW'(HoldCycles - 1);
      end
      S_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CntW'(TxnCycles - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          if (from_table_q) begin
            if (last_entry) begin
              table_active_d = 1'b0;
              init_done_d    = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
          if (from_table_q ? !last_entry : table_active_q) begin
            state_d      = S_LOAD;
            from_table_d = 1'b1;
          end else if (!q_empty) begin
            state_d      = S_LOAD;
            from_table_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    strobe_d = (state_d == S_ASSERT);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      idx_q          <= 3'd0;
      table_active_q <= 1'b0;
      from_table_q   <= 1'b0;
      init_done_q    <= 1'b0;
      strobe_q       <= 1'b0;
      busy_q         <= 1'b0;
      reg_q          <= 8'h00;
      data_q         <= 16'h0000;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      table_active_q <= table_active_d;
      from_table_q   <= from_table_d;
      init_done_q    <= init_done_d;
      strobe_q       <= strobe_d;
      busy_q         <= busy_d;
      reg_q          <= reg_d;
      data_q         <= data_d;
    end
  end

  assign send_special_i2c_command     = strobe_q;
  assign special_i2c_command_register = reg_q;
  assign special_i2c_command_data     = data_q;
  assign busy                         = busy_q;
  assign init_done                    = init_done_q;

endmodule

// File: tb/tb_i2c_command_sequencer.sv
// Directed bench for i2c_command_sequencer with a strobe-driven scoreboard.
// Host-queue scenarios run when I2C_HOST_QUEUE_EN is defined; otherwise the tied-off handshake is checked.
module tb_i2c_command_sequencer;

  localparam int unsigned H = 4;
  localparam int unsigned T = 20;
  localparam int unsigned D = 4;

`ifdef I2C_HOST_QUEUE_EN
  localparam bit QEn = 1'b1;
`else
  localparam bit QEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        host_cmd_valid;
  logic        host_cmd_ready;
  logic [7:0]  host_cmd_register;
  logic [15:0] host_cmd_data;
  logic        send;
  logic [7:0]  sreg;
  logic [15:0] sdata;
  logic        busy;
  logic        init_done;

  always #5 clk = ~clk;

  i2c_command_sequencer #(
    .HoldCycles (H),
    .TxnCycles  (T),
    .QueueDepth (D)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .start                        (start),
    .host_cmd_valid               (host_cmd_valid),
    .host_cmd_ready               (host_cmd_ready),
    .host_cmd_register            (host_cmd_register),
    .host_cmd_data                (host_cmd_data),
    .send_special_i2c_command     (send),
    .special_i2c_command_register (sreg),
    .special_i2c_command_data     (sdata),
    .busy                         (busy),
    .init_done                    (init_done)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_rise = -1;
  int          last_fall = -1;
  int          rise_count = 0;
  int          hi_len = 0;
  int          rc0;
  int          hs_cyc;
  bit          prev_strobe = 1'b0;
  bit          spacing_on = 1'b0;
  logic [23:0] cur_word = '0;
  logic [23:0] exp_word;
  logic [23:0] sb [$];
  logic [23:0] tbl [7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step, sampled 1ns after the edge, with the strobe monitor/scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (send && !prev_strobe) begin
      rise_count++;
      check("sb_nonempty_on_strobe", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        exp_word = sb.pop_front();
        check("strobe_register", 32'(sreg), 32'(exp_word[23:16]));
        check("strobe_data", 32'(sdata), 32'(exp_word[15:0]));
      end
      if (spacing_on && last_rise >= 0) begin
        check("load_spacing", 32'(cyc - last_rise), 32'(H + T + 1));
      end
      last_rise = cyc;
      cur_word  = {sreg, sdata};
    end else if (send && prev_strobe) begin
      check("hold_stable", 32'({sreg, sdata}), 32'(cur_word));
    end
    if (send) hi_len++;
    if (!send && prev_strobe) begin
      check("strobe_width", 32'(hi_len), 32'(H));
      hi_len    = 0;
      last_fall = cyc;
    end
    prev_strobe = send;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobe"}, 32'(send), 32'(0));
    check({tag, "_register"}, 32'(sreg), 32'(0));
    check({tag, "_data"}, 32'(sdata), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_init_done"}, 32'(init_done), 32'(0));
    check({tag, "_ready"}, 32'(host_cmd_ready), 32'(QEn));
  endtask

  task automatic load_table_sb();
    for (int i = 0; i < 7; i++) sb.push_back(tbl[i]);
  endtask

  initial begin
    tbl[0] = 24'h23_0033;
    tbl[1] = 24'h22_0033;
    tbl[2] = 24'h04_09FF;
    tbl[3] = 24'h03_077F;
    tbl[4] = 24'h01_0038;
    tbl[5] = 24'h20_0060;
    tbl[6] = 24'h1E_4146;

    reset             = 1'b1;
    start             = 1'b0;
    host_cmd_valid    = 1'b0;
    host_cmd_register = 8'h00;
    host_cmd_data     = 16'h0000;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Startup table with timing checks
    spacing_on = 1'b1;
    last_rise  = -1;
    load_table_sb();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_n_busy", 32'(busy), 32'(0));
    check("start_n_strobe", 32'(send), 32'(0));
    tick();
    check("load_busy", 32'(busy), 32'(1));
    check("load_strobe", 32'(send), 32'(0));
    tick();
    check("first_rise", 32'(send), 32'(1));

    // Start during replay must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;

`ifdef I2C_HOST_QUEUE_EN
    for (int i = 0; i < 5; i++) begin
      host_cmd_valid    = 1'b1;
      host_cmd_register = 8'(8'h40 + i);
      host_cmd_data     = 16'(16'hA000 + i);
      check("ready_during_replay", 32'(host_cmd_ready), 32'(i < 4));
      if (i < 4) sb.push_back({host_cmd_register, host_cmd_data});
      tick();
    end
    host_cmd_valid = 1'b0;
`endif

    repeat (30) tick();
    start = 1'b1;
    tick();
    start = 1'b0;

    for (int i = 0; i < 400 && !init_done; i++) tick();
    check("init_done_set", 32'(init_done), 32'(1));
    check("init_done_delay", 32'(cyc - last_fall), 32'(T));
    for (int i = 0; i < 400 && busy; i++) tick();
    check("replay_idle", 32'(busy), 32'(0));
    check("replay_strobes", 32'(rise_count), 32'(QEn ? 11 : 7));
    check("replay_sb_empty", 32'(sb.size()), 32'(0));

    // Start after init_done must be ignored
    spacing_on = 1'b0;
    rc0 = rise_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("late_start_strobes", 32'(rise_count), 32'(rc0));
    check("late_start_busy", 32'(busy), 32'(0));

    // Host write while idle
    host_cmd_valid    = 1'b1;
    host_cmd_register = 8'h35;
    host_cmd_data     = 16'h1234;
    check("idle_push_ready", 32'(host_cmd_ready), 32'(QEn));
`ifdef I2C_HOST_QUEUE_EN
    sb.push_back(24'h35_1234);
    tick();
    hs_cyc = cyc;
    host_cmd_valid = 1'b0;
    tick();
    check("idle_push_strobe_n1", 32'(send), 32'(0));
    tick();
    check("idle_push_strobe_n2", 32'(send), 32'(1));
    check("idle_push_rise_cycle", 32'(last_rise - hs_cyc), 32'(2));
    for (int i = 0; i < 100 && busy; i++) tick();
    check("idle_push_done", 32'(busy), 32'(0));
    check("idle_push_sb_empty", 32'(sb.size()), 32'(0));
`else
    rc0 = rise_count;
    tick();
    host_cmd_valid = 1'b0;
    repeat (40) tick();
    check("noqueue_no_strobe", 32'(rise_count), 32'(rc0));
    check("noqueue_idle", 32'(busy), 32'(0));
    check("noqueue_ready_low", 32'(host_cmd_ready), 32'(0));
`endif

    // Reset during ASSERT of table entry 3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rereset_init_done", 32'(init_done), 32'(0));
    rc0 = rise_count;
    load_table_sb();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && rise_count < rc0 + 4; i++) tick();
    check("entry3_reached", 32'(rise_count), 32'(rc0 + 4));
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    prev_strobe = 1'b0;
    hi_len      = 0;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("after_reset_no_strobe", 32'(rise_count), 32'(rc0 + 4));

    // Replay again from entry 0
    spacing_on = 1'b1;
    last_rise  = -1;
    load_table_sb();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && !init_done; i++) tick();
    check("replay2_init_done", 32'(init_done), 32'(1));
    check("replay2_strobes", 32'(rise_count), 32'(rc0 + 11));
    check("replay2_sb_empty", 32'(sb.size()), 32'(0));
    for (int i = 0; i < 100 && busy; i++) tick();
    check("replay2_idle", 32'(busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
